// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan sequencer.
package display_pkg;

  typedef enum logic {S_HI, S_TEMP} state_e;

  localparam logic [1:0] DIG_UNIT = 2'd0;
  localparam logic [1:0] DIG_HALF = 2'd1;
  localparam logic [1:0] DIG_ONES = 2'd2;
  localparam logic [1:0] DIG_TENS = 2'd3;

  localparam logic [3:0] ANODE_OFF = 4'hF;

endpackage

// File: rtl/display_scan_sequencer_scan_timer.sv
// Digit slot prescaler and scan counter; produces the digit select,
// active-low anode strobes (with leading blanking) and frame timing pulses.
module scan_timer
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned BLANK   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] select,
  output logic [3:0] anode,
  output logic       frame_end,
  output logic       frame_start
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    select_q, select_d;
  logic          frame_start_q, frame_start_d;
  logic          slot_end;

  always_comb begin
    slot_end      = (pcnt_q == PCNT_MAX);
    frame_end     = slot_end && (select_q == DIG_TENS);
    pcnt_d        = slot_end ? '0 : pcnt_q + 1'b1;
    select_d      = slot_end ? select_q + 2'd1 : select_q;
    // Registering frame_end lands the pulse on the first cycle of digit 0.
    frame_start_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q        <= '0;
      select_q      <= DIG_UNIT;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      select_q      <= select_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign select      = select_q;
  assign frame_start = frame_start_q;
  assign anode       = (32'(pcnt_q) < BLANK) ? ANODE_OFF : ~(4'b0001 << select_q);

endmodule

// File: rtl/display_scan_sequencer.sv
// Four-digit display sequencer: scan timing, one-entry temperature snapshot
// buffer committed at frame boundaries, and the "Hi" display mode machine.
module display_scan_sequencer
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK     = 1,
  parameter int unsigned HI_FRAMES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] temp_data,
  input  logic       temp_half,
  input  logic       temp_valid,
  output logic       temp_ready,
  input  logic       hi_req,
  output logic [1:0] select,
  output logic [3:0] anode,
  output logic [7:0] data,
  output logic       decimal,
  output logic       display_data,
  output logic       frame_start
);

  localparam int unsigned FW = $clog2(HI_FRAMES + 1);
  localparam logic [FW-1:0] FCNT_INIT = FW'(HI_FRAMES);

  logic          frame_end;
  state_e        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          hi_pend_q, hi_pend_d;
  logic          pend_full_q, pend_full_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic          pend_half_q, pend_half_d;
  logic [7:0]    data_q, data_d;
  logic          decimal_q, decimal_d;

  scan_timer #(
    .CLK_DIV (CLK_DIV),
    .BLANK   (BLANK)
  ) u_scan_timer (
    .clk         (clk),
    .rst_n       (reset),
    .select      (select),
    .anode       (anode),
    .frame_end   (frame_end),
    .frame_start (frame_start)
  );

  assign temp_ready = !pend_full_q;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    hi_pend_d   = hi_pend_q | hi_req;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    pend_half_d = pend_half_q;
    data_d      = data_q;
    decimal_d   = decimal_q;

    if (frame_end) begin
      if (pend_full_q) begin
        data_d      = pend_data_q;
        decimal_d   = pend_half_q;
        pend_full_d = 1'b0;
      end
      // A fresh hi_req in the same cycle stays pending for the following frame.
      if (hi_pend_q) begin
        state_d   = S_HI;
        fcnt_d    = FCNT_INIT;
        hi_pend_d = hi_req;
      end else if (state_q == S_HI) begin
        fcnt_d = fcnt_q - 1'b1;
        if (fcnt_q == FW'(1)) state_d = S_TEMP;
      end
    end

    // Accept only when empty, so this never races the frame-end drain above.
    if (temp_valid && temp_ready) begin
      pend_full_d = 1'b1;
      pend_data_d = temp_data;
      pend_half_d = temp_half;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HI;
      fcnt_q      <= FCNT_INIT;
      hi_pend_q   <= 1'b0;
      pend_full_q <= 1'b0;
      pend_data_q <= '0;
      pend_half_q <= 1'b0;
      data_q      <= '0;
      decimal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      hi_pend_q   <= hi_pend_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      pend_half_q <= pend_half_d;
      data_q      <= data_d;
      decimal_q   <= decimal_d;
    end
  end

  assign data         = data_q;
  assign decimal      = decimal_q;
  assign display_data = (state_q == S_HI);

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Self-checking bench: randomized producer/hi_req traffic against a
// cycle-count based reference model of the display sequencer.
module tb_display_scan_sequencer;

  localparam int unsigned CD = 4;
  localparam int unsigned BL = 1;
  localparam int unsigned HF = 2;
  localparam int unsigned FRAME = 4 * CD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] temp_data = '0;
  logic       temp_half = 1'b0;
  logic       temp_valid = 1'b0;
  logic       temp_ready;
  logic       hi_req = 1'b0;
  logic [1:0] select;
  logic [3:0] anode;
  logic [7:0] data;
  logic       decimal;
  logic       display_data;
  logic       frame_start;

  display_scan_sequencer #(
    .CLK_DIV   (CD),
    .BLANK     (BL),
    .HI_FRAMES (HF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .temp_data    (temp_data),
    .temp_half    (temp_half),
    .temp_valid   (temp_valid),
    .temp_ready   (temp_ready),
    .hi_req       (hi_req),
    .select       (select),
    .anode        (anode),
    .data         (data),
    .decimal      (decimal),
    .display_data (display_data),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: time since reset release plus abstract mode/buffer state.
  int unsigned t;
  bit          m_hi;
  int          m_left;
  bit          m_hpend;
  bit          m_pfull;
  logic [7:0]  m_pdata;
  bit          m_phalf;
  logic [7:0]  m_data;
  bit          m_dec;

  // Producer holding a word until it is taken.
  logic [7:0]  p_word;
  bit          p_half;
  bit          p_has;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_hi    = 1'b1;
    m_left  = HF;
    m_hpend = 1'b0;
    m_pfull = 1'b0;
    m_pdata = '0;
    m_phalf = 1'b0;
    m_data  = '0;
    m_dec   = 1'b0;
  endtask

  task automatic check_all();
    int unsigned sel;
    int unsigned exp_an;
    sel    = (t / CD) % 4;
    exp_an = ((t % CD) < BL) ? 15 : 15 - (1 << sel);
    chk("select", 32'(select), sel);
    chk("anode", 32'(anode), exp_an);
    chk("frame_start", 32'(frame_start), 32'((t % FRAME == 0) && (t != 0)));
    chk("display_data", 32'(display_data), 32'(m_hi));
    chk("data", 32'(data), 32'(m_data));
    chk("decimal", 32'(decimal), 32'(m_dec));
    chk("temp_ready", 32'(temp_ready), 32'(!m_pfull));
  endtask

  task automatic step(input bit allow_hi, input int unsigned vprob);
    bit fe;
    bit acc;
    check_all();
    if (!p_has && ($urandom_range(99) < vprob)) begin
      p_word = 8'($urandom);
      p_half = 1'($urandom);
      p_has  = 1'b1;
    end
    temp_valid = p_has;
    temp_data  = p_has ? p_word : 8'($urandom);
    temp_half  = p_has ? p_half : 1'($urandom);
    hi_req     = allow_hi && ($urandom_range(59) == 0);

    fe  = (t % FRAME) == FRAME - 1;
    acc = temp_valid && !m_pfull;
    if (fe) begin
      if (m_pfull) begin
        m_data  = m_pdata;
        m_dec   = m_phalf;
        m_pfull = 1'b0;
      end
      if (m_hpend) begin
        m_hi    = 1'b1;
        m_left  = HF;
        m_hpend = hi_req;
      end else begin
        if (m_hi) begin
          m_left--;
          if (m_left == 0) m_hi = 1'b0;
        end
        if (hi_req) m_hpend = 1'b1;
      end
    end else if (hi_req) begin
      m_hpend = 1'b1;
    end
    if (acc) begin
      m_pfull = 1'b1;
      m_pdata = temp_data;
      m_phalf = temp_half;
      p_has   = 1'b0;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    model_reset();
    p_has = 1'b0;
    p_word = '0;
    p_half = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Free run: scan pattern and the initial Hi window.
    repeat (40) step(1'b0, 0);

    // One word mid-frame.
    p_word = 8'd37;
    p_half = 1'b1;
    p_has  = 1'b1;
    repeat (40) step(1'b0, 0);

    // Producer always has a word: back-to-back offers.
    p_word = 8'd20;
    p_half = 1'b0;
    p_has  = 1'b1;
    repeat (60) step(1'b0, 100);

    // Mixed random traffic with hi_req pulses.
    repeat (600) step(1'b1, 30);

    // Async reset during digit 2 with a word pending.
    found = 1'b0;
    p_has = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (((t / CD) % 4 == 2) && m_pfull) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 100);
    end
    chk("reset_setup_reached", 32'(found), 32'd1);
    temp_valid = 1'b0;
    hi_req     = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    repeat (200) step(1'b1, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
